// File: rtl/touch_panel_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : touch_panel_adc_ctrl
//  Description : Touch-panel front end for an ADS7843-style ADC. Debounces
//                the raw pen interrupt and, while the pen is down, runs an X
//                then a Y 12-bit conversion over SPI. The coordinates are
//                latched into Avalon-MM readable registers, and an interrupt
//                is raised for each new pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_panel_adc_ctrl #(
   parameter int CLK_DIV  = 25,     // clk cycles per DCLK half-period (2..255)
   parameter int DEBOUNCE = 50000,  // stable synced cycles to toggle pen_down (>=2)
   parameter int GAP      = 500000  // idle clk cycles between pairs in continuous mode
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pen_irq_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        adc_dclk,
   output logic        adc_cs_n,
   output logic        adc_din,
   input  logic        adc_dout
);

   localparam int c_deb_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int c_gap_w = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE - 1);
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP - 1);
   localparam logic [7:0]         c_div_last = 8'(CLK_DIV - 1);

   // Control bytes: start, channel, 12-bit, differential, PD=00
   localparam logic [7:0] c_cmd_x = 8'hD0;
   localparam logic [7:0] c_cmd_y = 8'h90;

   // Last half-period index of a transfer: one lead-in half plus 48 periods
   localparam logic [6:0] c_half_last = 7'd96;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_XFER     = 2'd1,
      ST_UPDATE   = 2'd2,
      ST_GAP_WAIT = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_pen_s1;
   logic                 r_pen_s2;
   logic [c_deb_w-1:0]   r_deb_cnt;
   logic                 r_pen_down;
   logic                 r_need_release;
   logic                 r_dout_s1;
   logic                 r_dout_s2;
   logic [2:0]           r_ctrl;
   logic                 r_valid;
   logic [11:0]          r_x;
   logic [11:0]          r_y;
   logic [11:0]          r_sh_x;
   logic [11:0]          r_sh_y;
   logic [7:0]           r_div;
   logic [6:0]           r_half;
   logic [c_gap_w-1:0]   r_gap_cnt;

   logic                 w_enable;
   logic                 w_irq_en;
   logic                 w_cont;
   logic                 w_wr;
   logic                 w_rd;
   logic                 w_busy;
   logic                 w_update;
   logic                 w_launch;
   logic                 w_half_end;
   logic [6:0]           w_next_half;
   logic [6:0]           w_period;
   logic                 w_cmd_bit;
   logic                 w_sample_x;
   logic                 w_sample_y;
   logic [31:0]          w_rdata;
   logic                 w_unused;

   assign w_enable   = r_ctrl[0];
   assign w_irq_en   = r_ctrl[1];
   assign w_cont     = r_ctrl[2];
   assign w_wr       = chipselect & ~write_n;
   assign w_rd       = chipselect & write_n;
   assign w_busy     = (r_state == ST_XFER) || (r_state == ST_UPDATE);
   assign w_update   = (r_state == ST_UPDATE);
   assign w_half_end = (r_div == c_div_last);
   assign irq        = r_valid & w_irq_en;
   assign w_unused   = ^writedata[31:3];

   // A new pair starts from IDLE when armed (single-shot mode needs a fresh
   // press), or straight out of the gap when streaming with the pen held.
   assign w_launch =
      ((r_state == ST_IDLE) && w_enable && r_pen_down && (w_cont || !r_need_release)) ||
      ((r_state == ST_GAP_WAIT) && (r_gap_cnt == c_gap_last) && w_cont && w_enable && r_pen_down);

   // DCLK period number reached by the next half-period step; odd steps are
   // rising edges (sample point), even steps are falling edges (din update).
   always_comb begin
      w_next_half = r_half + 7'd1;
      w_period    = {1'b0, w_next_half[6:1]} + 7'd1;
      w_cmd_bit   = 1'b0;
      if ((w_period >= 7'd1) && (w_period <= 7'd8)) begin
         w_cmd_bit = c_cmd_x[3'(7'd8 - w_period)];
      end else if ((w_period >= 7'd25) && (w_period <= 7'd32)) begin
         w_cmd_bit = c_cmd_y[3'(7'd32 - w_period)];
      end
   end

   assign w_sample_x = (w_period >= 7'd10) && (w_period <= 7'd21);
   assign w_sample_y = (w_period >= 7'd34) && (w_period <= 7'd45);

   // Register read mux; upper bits of every register read as zero
   always_comb begin
      w_rdata = 32'h0;
      case (address)
         2'd0:    w_rdata = {20'h0, r_x};
         2'd1:    w_rdata = {20'h0, r_y};
         2'd2:    w_rdata = {29'h0, r_ctrl};
         default: w_rdata = {29'h0, w_busy, r_pen_down, r_valid};
      endcase
   end

   // Pen synchroniser and debouncer: count consecutive cycles in which the
   // synced level disagrees with pen_down; any agreement reloads the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pen_s1   <= 1'b1;
         r_pen_s2   <= 1'b1;
         r_deb_cnt  <= '0;
         r_pen_down <= 1'b0;
      end else begin
         r_pen_s1 <= pen_irq_n;
         r_pen_s2 <= r_pen_s1;
         if (!r_pen_s2 == r_pen_down) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == c_deb_last) begin
            r_deb_cnt  <= '0;
            r_pen_down <= ~r_pen_down;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

   // Double-synchronise the ADC serial output before it is sampled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dout_s1 <= 1'b0;
         r_dout_s2 <= 1'b0;
      end else begin
         r_dout_s1 <= adc_dout;
         r_dout_s2 <= r_dout_s1;
      end
   end

   // Bus registers: CTRL writes, valid flag (set beats clear), coordinate
   // latch, re-arm tracking and the registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl         <= 3'b000;
         r_valid        <= 1'b0;
         r_x            <= 12'h0;
         r_y            <= 12'h0;
         r_need_release <= 1'b0;
         readdata       <= 32'h0;
      end else begin
         if (w_wr && (address == 2'd2)) begin
            r_ctrl <= writedata[2:0];
         end
         if (w_update) begin
            r_valid <= 1'b1;
            r_x     <= r_sh_x;
            r_y     <= r_sh_y;
         end else if (w_wr && (address == 2'd3)) begin
            r_valid <= 1'b0;
         end
         if (!r_pen_down) begin
            r_need_release <= 1'b0;
         end else if (w_update) begin
            r_need_release <= 1'b1;
         end
         readdata <= w_rd ? w_rdata : 32'h0;
      end
   end

   // Conversion FSM with registered SPI outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_div     <= 8'h0;
         r_half    <= 7'h0;
         r_sh_x    <= 12'h0;
         r_sh_y    <= 12'h0;
         r_gap_cnt <= '0;
         adc_dclk  <= 1'b0;
         adc_cs_n  <= 1'b1;
         adc_din   <= 1'b0;
      end else if (w_launch) begin
         // cs_n drops with dclk low; the first command bit is presented for
         // a full half-period before the first rising edge.
         r_state  <= ST_XFER;
         r_div    <= 8'h0;
         r_half   <= 7'h0;
         adc_cs_n <= 1'b0;
         adc_dclk <= 1'b0;
         adc_din  <= c_cmd_x[7];
      end else begin
         case (r_state)
            ST_IDLE: begin
               adc_cs_n <= 1'b1;
               adc_dclk <= 1'b0;
               adc_din  <= 1'b0;
            end
            ST_XFER: begin
               if (!w_half_end) begin
                  r_div <= r_div + 8'd1;
               end else begin
                  r_div <= 8'h0;
                  if (r_half == c_half_last) begin
                     r_state  <= ST_UPDATE;
                     adc_cs_n <= 1'b1;
                     adc_dclk <= 1'b0;
                     adc_din  <= 1'b0;
                  end else begin
                     r_half <= w_next_half;
                     if (w_next_half[0]) begin
                        adc_dclk <= 1'b1;
                        if (w_sample_x) begin
                           r_sh_x <= {r_sh_x[10:0], r_dout_s2};
                        end
                        if (w_sample_y) begin
                           r_sh_y <= {r_sh_y[10:0], r_dout_s2};
                        end
                     end else begin
                        adc_dclk <= 1'b0;
                        adc_din  <= w_cmd_bit;
                     end
                  end
               end
            end
            ST_UPDATE: begin
               r_state   <= ST_GAP_WAIT;
               r_gap_cnt <= '0;
            end
            ST_GAP_WAIT: begin
               if (r_gap_cnt == c_gap_last) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_touch_panel_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_touch_panel_adc_ctrl
//  Description : Scoreboard bench for touch_panel_adc_ctrl with a behavioural
//                ADS7843 model returning random coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_panel_adc_ctrl;

   localparam int CD          = 4;
   localparam int DB          = 8;
   localparam int GP          = 40;
   localparam int XFER_CYC    = 97 * CD;
   localparam int PAIR_PERIOD = GP + XFER_CYC + 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pen_irq_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        adc_dclk;
   logic        adc_cs_n;
   logic        adc_din;
   logic        adc_dout;

   touch_panel_adc_ctrl #(.CLK_DIV(CD), .DEBOUNCE(DB), .GAP(GP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pen_irq_n  (pen_irq_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .adc_dclk   (adc_dclk),
      .adc_cs_n   (adc_cs_n),
      .adc_din    (adc_din),
      .adc_dout   (adc_dout)
   );

   always #5 clk = ~clk;

   typedef struct {logic [11:0] x; logic [11:0] y;} pair_t;
   typedef struct {string nm; logic [31:0] v;} rd_t;

   pair_t       adc_q[$];   // values the ADC model will return, per transfer
   pair_t       exp_q[$];   // transfers expected to complete
   rd_t         rd_q[$];    // expected read responses
   int          n_pass  = 0;
   int          n_total = 0;
   int unsigned cyc     = 0;
   logic        rd_fire = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
   endfunction

   function automatic void fail_evt(string nm);
      n_total++;
      $display("FAIL %s: event did not occur as required", nm);
   endfunction

   function automatic logic [31:0] status(logic v, logic p, logic b);
      return {29'h0, b, p, v};
   endfunction

   // Serial bit the ADC drives for a given rising-edge number
   function automatic logic adc_bit(pair_t p, int k);
      logic [11:0] v;
      if (k >= 10 && k <= 21) begin v = p.x; return v[21-k]; end
      if (k >= 34 && k <= 45) begin v = p.y; return v[45-k]; end
      return 1'b0;
   endfunction

   function automatic pair_t push_pair();
      pair_t p;
      p.x = 12'($urandom_range(0, 4095));
      p.y = 12'($urandom_range(0, 4095));
      adc_q.push_back(p);
      exp_q.push_back(p);
      return p;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      rd_fire = chipselect & write_n;
   end

   // Monitor: ADC model plus scoreboard for transfers and bus reads
   initial begin : mon
      rd_t   r;
      pair_t e;
      pair_t cur;
      logic  prev_cs, prev_dclk;
      int    rises, lowcnt, extra;
      logic [7:0] cmdx, cmdy;
      prev_cs = 1'b1; prev_dclk = 1'b0;
      rises = 0; lowcnt = 0; extra = 0; cmdx = 8'h0; cmdy = 8'h0;
      cur.x = 12'h0; cur.y = 12'h0;
      adc_dout = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_fire) begin
            if (rd_q.size() == 0) fail_evt("unexpected_read");
            else begin r = rd_q.pop_front(); chk(r.nm, readdata, r.v); end
         end
         if (prev_cs && !adc_cs_n) begin
            if (adc_q.size() != 0) cur = adc_q.pop_front();
            else begin cur.x = 12'h0; cur.y = 12'h0; end
            rises = 0; lowcnt = 1; extra = 0; cmdx = 8'h0; cmdy = 8'h0;
            adc_dout = 1'b0;
         end else if (!adc_cs_n) begin
            lowcnt++;
         end
         if (!adc_cs_n && !prev_dclk && adc_dclk) begin
            rises++;
            if (rises >= 1 && rises <= 8) cmdx = {cmdx[6:0], adc_din};
            else if (rises >= 25 && rises <= 32) cmdy = {cmdy[6:0], adc_din};
            else if (adc_din) extra++;
         end
         if (!adc_cs_n && prev_dclk && !adc_dclk) adc_dout = adc_bit(cur, rises + 1);
         if (!prev_cs && adc_cs_n && reset_n) begin
            if (exp_q.size() == 0) fail_evt("unexpected_xfer");
            else begin
               e = exp_q.pop_front();
               chk("xfer_dclk_count", rises, 48);
               chk("xfer_cs_low_cycles", lowcnt, XFER_CYC);
               chk("xfer_cmd_x", {24'h0, cmdx}, 32'hD0);
               chk("xfer_cmd_y", {24'h0, cmdy}, 32'h90);
               chk("xfer_din_spare_zero", extra, 0);
            end
         end
         prev_cs   = adc_cs_n;
         prev_dclk = adc_dclk;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cs(input logic lvl, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (adc_cs_n === lvl) return;
      end
      fail_evt(nm);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
      rd_t r;
      r.nm = nm; r.v = e;
      rd_q.push_back(r);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0;
   endtask

   initial begin
      pair_t p;
      int unsigned t_prev;
      reset_n = 1'b0; pen_irq_n = 1'b1; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;

      // Reset state
      tick(3);
      chk("rst_cs_n", {31'h0, adc_cs_n}, 1);
      chk("rst_dclk", {31'h0, adc_dclk}, 0);
      chk("rst_din", {31'h0, adc_din}, 0);
      chk("rst_irq", {31'h0, irq}, 0);
      chk("rst_readdata", readdata, 0);
      reset_n = 1'b1;
      tick(2);
      for (int a = 0; a < 4; a++) bus_read(2'(a), 32'h0, "rst_read_reg");

      // Pen low one cycle short of the debounce count: must not register
      bus_write(2'd2, 32'h1);
      pen_irq_n = 1'b0;
      tick(DB - 1);
      pen_irq_n = 1'b1;
      tick(DB + 10);
      bus_read(2'd3, status(0, 0, 0), "short_press_status");
      chk("short_press_cs_n", {31'h0, adc_cs_n}, 1);

      // Single pair with fixed coordinates
      p.x = 12'hA5C; p.y = 12'h3F1;
      adc_q.push_back(p); exp_q.push_back(p);
      bus_write(2'd2, 32'h3);
      pen_irq_n = 1'b0;
      wait_cs(1'b0, DB + 20, "t3_start");
      wait_cs(1'b1, XFER_CYC + 20, "t3_done");
      tick(3);
      bus_read(2'd0, 32'hA5C, "t3_x");
      bus_read(2'd1, 32'h3F1, "t3_y");
      bus_read(2'd2, 32'h3, "t3_ctrl");
      bus_read(2'd3, status(1, 1, 0), "t3_status");
      chk("t3_irq", {31'h0, irq}, 1);
      // Single-shot: holding the pen must not start another pair
      tick(3 * PAIR_PERIOD);
      chk("t3_no_repeat_cs_n", {31'h0, adc_cs_n}, 1);

      // Clearing valid drops irq on the next cycle
      bus_write(2'd3, 32'h0);
      chk("t4_irq_after_clear", {31'h0, irq}, 0);
      bus_read(2'd3, status(0, 1, 0), "t4_status_cleared");
      bus_read(2'd0, 32'hA5C, "t4_write_x_ignored");
      // Release and re-press; clear lands in the UPDATE cycle
      pen_irq_n = 1'b1;
      tick(DB + 5);
      bus_read(2'd3, status(0, 0, 0), "t4_released");
      p = push_pair();
      pen_irq_n = 1'b0;
      wait_cs(1'b0, DB + 20, "t4_start");
      wait_cs(1'b1, XFER_CYC + 20, "t4_done");
      address = 2'd3; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      tick(2);
      bus_read(2'd3, status(1, 1, 0), "t4_set_wins_status");
      chk("t4_set_wins_irq", {31'h0, irq}, 1);
      bus_read(2'd0, {20'h0, p.x}, "t4_x");
      bus_read(2'd1, {20'h0, p.y}, "t4_y");

      // Continuous mode with pen held; release during the fourth pair
      for (int i = 0; i < 3; i++) p = push_pair();
      p = push_pair();
      bus_write(2'd2, 32'h7);
      wait_cs(1'b0, PAIR_PERIOD + 20, "t5_start");
      t_prev = cyc;
      for (int i = 0; i < 3; i++) begin
         wait_cs(1'b1, XFER_CYC + 20, "t5_done");
         wait_cs(1'b0, GP + 20, "t5_next");
         chk("t5_pair_period", cyc - t_prev, PAIR_PERIOD);
         t_prev = cyc;
      end
      tick(20);
      pen_irq_n = 1'b1;
      wait_cs(1'b1, XFER_CYC + 20, "t5_last_done");
      tick(2 * PAIR_PERIOD);
      chk("t5_stopped_cs_n", {31'h0, adc_cs_n}, 1);
      bus_read(2'd0, {20'h0, p.x}, "t5_x");
      bus_read(2'd1, {20'h0, p.y}, "t5_y");
      bus_read(2'd3, status(1, 0, 0), "t5_status");

      // Asynchronous reset during a transfer
      p.x = 12'($urandom_range(0, 4095)); p.y = 12'($urandom_range(0, 4095));
      adc_q.push_back(p);
      pen_irq_n = 1'b0;
      wait_cs(1'b0, DB + 20, "t6_start");
      tick(50);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_cs_n", {31'h0, adc_cs_n}, 1);
      chk("t6_async_dclk", {31'h0, adc_dclk}, 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick(DB + 60);
      chk("t6_idle_after_reset", {31'h0, adc_cs_n}, 1);
      bus_read(2'd0, 32'h0, "t6_x_cleared");
      bus_read(2'd1, 32'h0, "t6_y_cleared");
      bus_read(2'd2, 32'h0, "t6_ctrl_cleared");
      bus_read(2'd3, status(0, 1, 0), "t6_status");
      p = push_pair();
      bus_write(2'd2, 32'h1);
      wait_cs(1'b0, 20, "t6_restart");
      wait_cs(1'b1, XFER_CYC + 20, "t6_done");
      tick(3);
      bus_read(2'd0, {20'h0, p.x}, "t6_x");
      bus_read(2'd1, {20'h0, p.y}, "t6_y");
      bus_read(2'd3, status(1, 1, 0), "t6_status_valid");
      chk("t6_irq_masked", {31'h0, irq}, 0);

      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
